dpram_port_arbiter: RTL and testbench

- Shares one port of the byte-write-enabled dual-port RAM between two requesters, e.g. the MAC RX/TX DMA engine and the CPU bus bridge.
- Round-robin arbitration with a req/gnt handshake.
- Tracks the RAM's one-cycle registered-address read latency and returns read data with a per-requester rvalid strobe.
- Instantiated once per shared RAM port, directly in front of it.

---
 rtl/dpram_port_arbiter_if.sv | 32 +++
 rtl/dpram_port_arbiter.sv | 72 +++++++
 tb/tb_dpram_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dpram_port_arbiter_if.sv
// dpram_port_arbiter_if: requester-side and RAM-side signals of one shared RAM port.
interface dpram_port_arbiter_if #(
  parameter int RAM_SIZE = 16,
  parameter int BYTE_WIDTH = 8
);
  logic                    m0_req, m1_req;
  logic [BYTE_WIDTH-1:0]   m0_we, m1_we;
  logic [RAM_SIZE-1:0]     m0_addr, m1_addr;
  logic [BYTE_WIDTH*8-1:0] m0_wrdata, m1_wrdata;
  logic                    m0_lock, m1_lock;
  logic                    m0_gnt, m1_gnt;
  logic                    m0_rvalid, m1_rvalid;
  logic [BYTE_WIDTH*8-1:0] m0_rddata, m1_rddata;
  logic                    ram_en;
  logic [BYTE_WIDTH-1:0]   ram_we;
  logic [RAM_SIZE-1:0]     ram_addr;
  logic [BYTE_WIDTH*8-1:0] ram_wrdata, ram_rddata;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wrdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wrdata, m1_lock,
    output m0_gnt, m0_rvalid, m0_rddata, m1_gnt, m1_rvalid, m1_rddata,
    output ram_en, ram_we, ram_addr, ram_wrdata,
    input  ram_rddata
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wrdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wrdata, m1_lock,
    input  m0_gnt, m0_rvalid, m0_rddata, m1_gnt, m1_rvalid, m1_rddata,
    input  ram_en, ram_we, ram_addr, ram_wrdata,
    output ram_rddata
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one RAM port between two requesters.
// Define DPRAM_ARB_LOCK_EN to let a granted requester hold priority via m*_lock.
module dpram_port_arbiter #(
  parameter int RAM_SIZE = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int LOCK_MAX = 16
) (
  input logic ram_clk,
  input logic ram_rstn,
  dpram_port_arbiter_if.slave bus
);
  localparam int DW = BYTE_WIDTH*8;
  logic r_prio, r_rv0, r_rv1;
  logic [RAM_SIZE-1:0] r_addr;
  logic [DW-1:0] r_wrdata;
  logic w_gnt0, w_gnt1, w_any, w_rd, w_hold, w_rv0, w_rv1;
  logic [BYTE_WIDTH-1:0] w_we;
  logic [RAM_SIZE-1:0] w_addr;
  logic [DW-1:0] w_wrdata;
  always_comb begin
    w_gnt0 = ram_rstn & bus.m0_req & (~bus.m1_req | ~r_prio);
    w_gnt1 = ram_rstn & bus.m1_req & (~bus.m0_req | r_prio);
    w_any = w_gnt0 | w_gnt1;
    w_we = w_gnt0 ? bus.m0_we : w_gnt1 ? bus.m1_we : '0;
    w_addr = w_gnt0 ? bus.m0_addr : w_gnt1 ? bus.m1_addr : r_addr;
    w_wrdata = w_gnt0 ? bus.m0_wrdata : w_gnt1 ? bus.m1_wrdata : r_wrdata;
    w_rd = w_any & ~|w_we;
    w_rv0 = r_rv0 & ram_rstn;
    w_rv1 = r_rv1 & ram_rstn;
  end
  assign bus.m0_gnt = w_gnt0;
  assign bus.m1_gnt = w_gnt1;
  assign bus.ram_en = w_any;
  assign bus.ram_we = w_we;
  assign bus.ram_addr = w_addr;
  assign bus.ram_wrdata = w_wrdata;
  assign bus.m0_rvalid = w_rv0;
  assign bus.m1_rvalid = w_rv1;
  assign bus.m0_rddata = w_rv0 ? bus.ram_rddata : '0;
  assign bus.m1_rddata = w_rv1 ? bus.ram_rddata : '0;
`ifdef DPRAM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);
  logic [CW-1:0] r_lock_cnt;
  // The grant that would reach LOCK_MAX is treated as unlocked so the other side gets a turn
  assign w_hold = w_any & (w_gnt0 ? bus.m0_lock : bus.m1_lock) & (r_lock_cnt != LOCK_LAST);
  always_ff @(posedge ram_clk) begin
    r_lock_cnt <= (!ram_rstn || !w_hold) ? '0 : r_lock_cnt + 1'b1;
  end
`else
  logic w_unused;
  assign w_hold = 1'b0;
  assign w_unused = ^{bus.m0_lock, bus.m1_lock, 32'(LOCK_MAX)};
`endif
  always_ff @(posedge ram_clk) begin
    if (!ram_rstn) begin
      r_prio <= 1'b0;
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      r_addr <= '0;
      r_wrdata <= '0;
    end else begin
      r_rv0 <= w_rd & w_gnt0;
      r_rv1 <= w_rd & w_gnt1;
      if (w_any) begin
        r_prio <= w_hold ? w_gnt1 : w_gnt0;
        r_addr <= w_addr;
        r_wrdata <= w_wrdata;
      end
    end
  end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed vectors against a behavioural registered-read RAM.
module tb_dpram_port_arbiter;
  logic clk, rstn;
  int n_chk = 0, n_fail = 0;
  logic [63:0] mem [0:255];
  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  dpram_port_arbiter_if #(.RAM_SIZE(16), .BYTE_WIDTH(8)) bus();
  dpram_port_arbiter #(.RAM_SIZE(16), .BYTE_WIDTH(8), .LOCK_MAX(4)) dut (
    .ram_clk(clk),
    .ram_rstn(rstn),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    logic [63:0] w;
    if (bus.ram_en) begin
      w = mem[bus.ram_addr[7:0]];
      for (int b = 0; b < 8; b++) if (bus.ram_we[b]) w[b*8 +: 8] = bus.ram_wrdata[b*8 +: 8];
      mem[bus.ram_addr[7:0]] <= w;
      bus.ram_rddata <= w;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic drv(input int m, input logic r, input logic [7:0] we, input logic [15:0] a, input logic [63:0] d);
    if (m == 0) begin
      bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wrdata = d;
    end else begin
      bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wrdata = d;
    end
  endtask
  function automatic logic [1:0] gv();
    return {bus.m0_gnt, bus.m1_gnt};
  endfunction
  function automatic logic [1:0] rv();
    return {bus.m0_rvalid, bus.m1_rvalid};
  endfunction
  initial begin
    logic [1:0] prev, exp_g;
    logic [11:0] lock_seq;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clk = 0;
    rstn = 0;
    bus.ram_rddata = '0;
    bus.m0_lock = 0;
    bus.m1_lock = 0;
    drv(0, 1, 8'h00, 16'h0000, '0);
    drv(1, 1, 8'h00, 16'h0000, '0);
    nxt;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("rst_quiet", {bus.m0_gnt, bus.m1_gnt, bus.ram_en, bus.m0_rvalid, bus.m1_rvalid, bus.ram_we}, '0);
      nxt;
    end
    rstn = 1;
    smp;
    chk("post_rst_gnt", gv(), 2'b10);
    chk("post_rst_en", bus.ram_en, 1);
    nxt;
    drv(0, 0, 8'h00, 16'h0000, '0);
    drv(1, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("post_rst_rv", rv(), 2'b10);
    chk("post_rst_rd0", bus.m0_rddata, 64'h0);
    nxt;
    drv(0, 1, 8'hFF, 16'h0010, D1);
    smp;
    chk("wr_gnt", gv(), 2'b10);
    chk("wr_we", bus.ram_we, 8'hFF);
    chk("wr_addr", bus.ram_addr, 16'h0010);
    nxt;
    drv(0, 1, 8'h00, 16'h0010, '0);
    smp;
    chk("raw_gnt", gv(), 2'b10);
    chk("wr_no_rv", rv(), 2'b00);
    nxt;
    drv(0, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("raw_rv", rv(), 2'b10);
    chk("raw_rd0", bus.m0_rddata, D1);
    chk("raw_rd1_zero", bus.m1_rddata, 64'h0);
    chk("idle_en", {bus.ram_en, bus.ram_we}, '0);
    chk("idle_addr_hold", bus.ram_addr, 16'h0010);
    nxt;
    drv(1, 1, 8'h01, 16'h0020, 64'h5555_5555_5555_55AA);
    smp;
    chk("pw_gnt", gv(), 2'b01);
    nxt;
    drv(1, 1, 8'h00, 16'h0020, '0);
    smp;
    chk("pw_rd_gnt", gv(), 2'b01);
    nxt;
    drv(1, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("pw_rv", rv(), 2'b01);
    chk("pw_rd1", bus.m1_rddata, 64'h0000_0000_0000_00AA);
    nxt;
    drv(0, 1, 8'h00, 16'h0010, '0);
    drv(1, 1, 8'h00, 16'h0020, '0);
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      smp;
      exp_g = (i % 2 == 1) ? 2'b01 : 2'b10;
      chk("rr_gnt", gv(), exp_g);
      chk("rr_rv", rv(), prev);
      chk("rr_rd0", bus.m0_rddata, prev[1] ? D1 : 64'h0);
      chk("rr_rd1", bus.m1_rddata, prev[0] ? 64'hAA : 64'h0);
      prev = exp_g;
      nxt;
    end
    drv(0, 0, 8'h00, 16'h0000, '0);
    drv(1, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("rr_last_rv", rv(), 2'b01);
    chk("rr_last_rd1", bus.m1_rddata, 64'hAA);
    nxt;
    drv(0, 1, 8'hF0, 16'h0030, 64'hDEAD_BEEF_CAFE_F00D);
    drv(1, 1, 8'h00, 16'h0030, '0);
    smp;
    chk("wr_rd_gnt0", gv(), 2'b10);
    nxt;
    drv(0, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("wr_rd_gnt1", gv(), 2'b01);
    chk("wr_rd_no_rv", rv(), 2'b00);
    nxt;
    drv(1, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("wr_rd_rv", rv(), 2'b01);
    chk("wr_rd_rd1", bus.m1_rddata, 64'hDEAD_BEEF_0000_0000);
    nxt;
`ifdef DPRAM_ARB_LOCK_EN
    lock_seq = 12'b10_10_10_10_01_10;
`else
    lock_seq = 12'b10_01_10_01_10_01;
`endif
    bus.m0_lock = 1;
    drv(0, 1, 8'h00, 16'h0010, '0);
    drv(1, 1, 8'h00, 16'h0020, '0);
    for (int i = 0; i < 6; i++) begin
      smp;
      exp_g = lock_seq[11 - 2*i -: 2];
      chk("lock_gnt", gv(), exp_g);
      nxt;
    end
    bus.m0_lock = 0;
    drv(0, 0, 8'h00, 16'h0000, '0);
    drv(1, 0, 8'h00, 16'h0000, '0);
    smp;
    nxt;
    drv(0, 1, 8'h00, 16'h0010, '0);
    smp;
    chk("rst_rd_gnt", gv(), 2'b10);
    nxt;
    rstn = 0;
    drv(0, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("rst_rd_drop_rv", rv(), 2'b00);
    chk("rst_rd_drop_data", bus.m0_rddata, 64'h0);
    nxt;
    smp;
    chk("rst_rd_hold_rv", rv(), 2'b00);
    nxt;
    rstn = 1;
    drv(0, 1, 8'h00, 16'h0010, '0);
    drv(1, 1, 8'h00, 16'h0020, '0);
    smp;
    chk("rst_prio", gv(), 2'b10);
    nxt;
    drv(0, 0, 8'h00, 16'h0000, '0);
    drv(1, 0, 8'h00, 16'h0000, '0);
    smp;
    chk("rst_after_rv", rv(), 2'b10);
    chk("rst_after_rd0", bus.m0_rddata, D1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
